instruction_fetcher: RTL



---
 rtl/instruction_fetcher.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetcher.sv
// Fetch stage: generates the PC, issues word fetches, and buffers the
// returned words with their PCs in a small in-order queue for the decoder.
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   imem_req_valid/addr/ready      fetch request channel to instruction memory
//   imem_resp_valid/data           in-order response words (never back-pressured)
//   redirect_valid/pc              control-flow change; flushes queue
//   instr_valid/instr/instr_pc     queue head presented to the decoder
//   instr_ready                    decoder consumes the head
module instruction_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH,
        FLUSH
    } state_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop_cnt;
    logic [CW-1:0]  q_cnt;
    logic [AW-1:0]  q_rd;
    logic [AW-1:0]  q_wr;
    logic [AW-1:0]  p_rd;
    logic [AW-1:0]  p_wr;

    logic [31:0]    q_word [DEPTH];
    logic [31:0]    q_pc   [DEPTH];
    logic [31:0]    pc_mem [DEPTH];

    logic           credit_ok;
    logic           req_fire;
    logic           head_pop;
    logic           resp_take;
    logic [CW-1:0]  out_net;
    logic           unused_bits;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Low address bits of a redirect target are discarded.
    assign unused_bits = ^redirect_pc[1:0];

    // Credits cover both in-flight requests and words already buffered,
    // so every response is guaranteed a queue slot.
    assign credit_ok = ((CW+1)'(outstanding) + (CW+1)'(q_cnt)) < DEPTH_W;

    assign imem_req_valid = reset_n && (state == FETCH) && credit_ok
                            && !redirect_valid;
    assign imem_req_addr  = fetch_pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign instr_valid = (q_cnt != '0);
    assign head_pop  = instr_valid && instr_ready;
    assign resp_take = imem_resp_valid && (state == FETCH) && !redirect_valid;

    // A response landing in the redirect cycle is itself stale.
    assign out_net = (imem_resp_valid && outstanding != '0)
                     ? outstanding - 1'b1 : outstanding;

    assign instr    = instr_valid ? q_word[q_rd] : NOP;
    assign instr_pc = instr_valid ? q_pc[q_rd]   : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_cnt       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            p_rd        <= '0;
            p_wr        <= '0;
        end else if (redirect_valid) begin
            q_cnt       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            p_rd        <= '0;
            p_wr        <= '0;
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            outstanding <= out_net;
            drop_cnt    <= out_net;
            state       <= (out_net != '0) ? FLUSH : FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    if (req_fire) begin
                        p_wr     <= nxt(p_wr);
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                    if (imem_resp_valid) begin
                        p_rd <= nxt(p_rd);
                        q_wr <= nxt(q_wr);
                    end
                    if (head_pop) begin
                        q_rd <= nxt(q_rd);
                    end
                    q_cnt <= q_cnt + CW'(imem_resp_valid) - CW'(head_pop);
                    outstanding <= outstanding + CW'(req_fire)
                                   - CW'(imem_resp_valid);
                end
                FLUSH: begin
                    if (imem_resp_valid) begin
                        drop_cnt    <= drop_cnt - 1'b1;
                        outstanding <= outstanding - 1'b1;
                        if (drop_cnt == CW'(1)) begin
                            state <= FETCH;
                        end
                    end
                end
            endcase
        end
    end

    // Storage arrays need no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[p_wr] <= fetch_pc;
        end
        if (resp_take) begin
            q_word[q_wr] <= imem_resp_data;
            q_pc[q_wr]   <= pc_mem[p_rd];
        end
    end

endmodule
